alu_result_capture: RTL and testbench
=====================================

ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; power of two, 2..64.
REQ-002 Parameter CNT_W, default 16, drop-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  alu result sample present this cycle.
REQ-006 in_funct  input  6  funct code that produced the sample.
REQ-007 in_s  input  32  alu result s.
REQ-008 in_ov / in_cc / in_cs  input  1 each  alu ov, cc, cs flags.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_funct  output  6, out_s  output  32, out_ov / out_cc / out_cs  output  1 each  head entry fields.
REQ-012 level  output  log2(DEPTH)+1  entries held.
REQ-013 full / empty  output  1 each  level==DEPTH / level==0.
REQ-014 drop_cnt  output  CNT_W  samples lost because FIFO full.
REQ-015 sticky_ov / sticky_cs  output  1 each  any accepted sample had ov / cs set.
REQ-016 clr  input  1  clears drop_cnt and sticky flags; FIFO untouched.

Function
REQ-017 Entry = {funct, s, ov, cc, cs}, 41 bits, stored unmodified.
REQ-018 Pop occurs when out_valid && out_ready; head pointer advances one entry.
REQ-019 Push occurs when in_valid && (!full || pop); sample written at tail, tail advances.
REQ-020 Full with simultaneous pop: push accepted, level stays DEPTH, no drop.
REQ-021 Empty with out_ready high and in_valid high: push only, no pop; out_valid rises next cycle.
REQ-022 Show-ahead output: out_* driven from storage at head pointer; out_valid = !empty; no added output register.
REQ-023 Latency: sample pushed at edge N appears on out_* after edge N when FIFO was empty.
REQ-024 out_* hold stable while out_valid && !out_ready.
REQ-025 Pointers log2(DEPTH) bits, wrap modulo DEPTH; level updates +1 push-only, -1 pop-only, unchanged both/neither.
REQ-026 Drop: in_valid && full && !pop increments drop_cnt; saturates at all-ones, no wrap.
REQ-027 sticky_ov sets on push with in_ov=1; sticky_cs sets on push with in_cs=1; dropped samples never set flags.
REQ-028 clr priority: clr clears first, same-cycle event then applied (clr+drop gives drop_cnt=1; clr+flagged push gives flag=1).
REQ-029 out_* contents when empty are don't-care; benches check only under out_valid.

Reset
REQ-030 rst at edge: pointers 0, level 0, empty=1, full=0, out_valid=0, drop_cnt 0, sticky flags 0.
REQ-031 rst has priority over push, pop and clr in the same cycle; in-flight entries discarded.
REQ-032 Storage array needs no reset.

Verification
REQ-033 Single: push {funct=6'h04, s=32'h8000061E, ov=0, cc=0, cs=0}, out_ready=1 -> out_valid one cycle later with those fields, then empty=1.
REQ-034 Fill: 4 pushes funct 6'h04..6'h07, out_ready=0 -> full=1, level=4; 5th push -> drop_cnt=1, contents unchanged; drain returns 6'h04..6'h07 in order.
REQ-035 Full+simultaneous: full, in_valid=1, out_ready=1 -> head popped, new sample stored, level=4, drop_cnt stays.
REQ-036 Flags: push ov=1 cs=0 then ov=0 cs=1 -> sticky_ov=1, sticky_cs=1; clr with flagged push same cycle -> flags remain 1; clr alone -> 0.
REQ-037 Wrap/saturate: 10 push/pop pairs across pointer wrap -> order preserved; CNT_W=4 with 20 drops -> drop_cnt=15.
REQ-038 Reset mid-op: level=3, assert rst with in_valid=1 -> next cycle level=0, out_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/alu_result_capture.sv
// Show-ahead FIFO capturing ALU result samples {funct, s, ov, cc, cs}, with a
// saturating drop counter for samples lost to a full FIFO and sticky ov/cs flags.
module alu_result_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [5:0]               in_funct,
  input  logic [31:0]              in_s,
  input  logic                     in_ov,
  input  logic                     in_cc,
  input  logic                     in_cs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_funct,
  output logic [31:0]              out_s,
  output logic                     out_ov,
  output logic                     out_cc,
  output logic                     out_cs,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     sticky_ov,
  output logic                     sticky_cs,
  input  logic                     clr
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam int unsigned EntW  = 41;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             sticky_ov_q, sticky_ov_d;
  logic             sticky_cs_q, sticky_cs_d;

  logic            push, pop, drop;
  logic [EntW-1:0] head;

  assign full      = (level_q == LvlW'(DEPTH));
  assign empty     = (level_q == '0);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  assign head = mem_q[rd_ptr_q];
  assign {out_funct, out_s, out_ov, out_cc, out_cs} = head;

  assign level     = level_q;
  assign drop_cnt  = drop_q;
  assign sticky_ov = sticky_ov_q;
  assign sticky_cs = sticky_cs_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // clr acts first so a same-cycle drop or flagged push still registers.
    drop_d      = clr ? '0 : drop_q;
    sticky_ov_d = clr ? 1'b0 : sticky_ov_q;
    sticky_cs_d = clr ? 1'b0 : sticky_cs_q;
    if (drop && (drop_d != '1)) drop_d = drop_d + CNT_W'(1);
    if (push && in_ov) sticky_ov_d = 1'b1;
    if (push && in_cs) sticky_cs_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      sticky_ov_q <= 1'b0;
      sticky_cs_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
      sticky_ov_q <= sticky_ov_d;
      sticky_cs_q <= sticky_cs_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_funct, in_s, in_ov, in_cc, in_cs};
  end

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed-vector bench for alu_result_capture: default instance plus a CNT_W=4
// instance for drop-counter saturation.
module tb_alu_result_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, clr;
  logic [5:0]  in_funct;
  logic [31:0] in_s;
  logic        in_ov, in_cc, in_cs;
  logic        out_valid, full, empty, sticky_ov, sticky_cs;
  logic [5:0]  out_funct;
  logic [31:0] out_s;
  logic        out_ov, out_cc, out_cs;
  logic [2:0]  level;
  logic [15:0] drop_cnt;

  logic        in_valid4, out_ready4, clr4;
  logic        out_valid4, full4, empty4, sticky_ov4, sticky_cs4;
  logic [5:0]  out_funct4;
  logic [31:0] out_s4;
  logic        out_ov4, out_cc4, out_cs4;
  logic [2:0]  level4;
  logic [3:0]  drop_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_capture #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_funct(in_funct), .in_s(in_s),
    .in_ov(in_ov), .in_cc(in_cc), .in_cs(in_cs), .out_valid(out_valid),
    .out_ready(out_ready), .out_funct(out_funct), .out_s(out_s), .out_ov(out_ov),
    .out_cc(out_cc), .out_cs(out_cs), .level(level), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .sticky_ov(sticky_ov), .sticky_cs(sticky_cs), .clr(clr)
  );

  alu_result_capture #(.DEPTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_funct(in_funct), .in_s(in_s),
    .in_ov(in_ov), .in_cc(in_cc), .in_cs(in_cs), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_funct(out_funct4), .out_s(out_s4), .out_ov(out_ov4),
    .out_cc(out_cc4), .out_cs(out_cs4), .level(level4), .full(full4), .empty(empty4),
    .drop_cnt(drop_cnt4), .sticky_ov(sticky_ov4), .sticky_cs(sticky_cs4), .clr(clr4)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [5:0] f, input logic [31:0] s,
                        input logic ov, input logic cc, input logic cs);
    in_valid = v;
    in_funct = f;
    in_s     = s;
    in_ov    = ov;
    in_cc    = cc;
    in_cs    = cs;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; clr4 = 1'b0;
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_sticky", {sticky_ov, sticky_cs}, 0);

    // Single sample, consumer ready while empty: push only.
    set_in(1'b1, 6'h04, 32'h8000061E, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("single_valid", out_valid, 1);
    check_eq("single_entry", {out_funct, out_s, out_ov, out_cc, out_cs},
             {6'h04, 32'h8000061E, 3'b000});
    check_eq("single_level", level, 1);
    step();
    check_eq("single_empty", empty, 1);

    // Fill with consumer stalled, then overflow with a flagged sample.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 6'(4 + i), 32'hA5A50000 + 32'(i), 1'b0, i[0], 1'b0);
      step();
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_level", level, 4);
    set_in(1'b1, 6'h3F, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
    step();
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("drop_cnt1", drop_cnt, 1);
    check_eq("drop_no_flags", {sticky_ov, sticky_cs}, 0);
    check_eq("drop_level", level, 4);
    check_eq("stall_head", {out_funct, out_s}, {6'h04, 32'hA5A50000});
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_valid", out_valid, 1);
      check_eq("drain_entry", {out_funct, out_s, out_cc},
               {6'(4 + i), 32'hA5A50000 + 32'(i), 1'(i % 2)});
      step();
    end
    check_eq("drain_empty", empty, 1);

    // Full with simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 6'(16 + i), 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 6'h14, 32'h4, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("simul_level", level, 4);
    check_eq("simul_drop", drop_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      check_eq("simul_order", out_funct, 6'(17 + i));
      step();
    end
    check_eq("simul_empty", empty, 1);

    // Sticky flags and clr interplay.
    set_in(1'b1, 6'h01, 32'h1, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("sticky_ov_only", {sticky_ov, sticky_cs}, 2'b10);
    set_in(1'b1, 6'h02, 32'h2, 1'b0, 1'b0, 1'b1);
    step();
    check_eq("sticky_both", {sticky_ov, sticky_cs}, 2'b11);
    set_in(1'b1, 6'h03, 32'h3, 1'b1, 1'b0, 1'b1);
    clr = 1'b1;
    step();
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("clr_push_flags", {sticky_ov, sticky_cs}, 2'b11);
    check_eq("clr_drop_zero", drop_cnt, 0);
    step();
    clr = 1'b0;
    check_eq("clr_alone_flags", {sticky_ov, sticky_cs}, 2'b00);
    step();
    step();
    check_eq("flags_drained", empty, 1);

    // Ten push/pop pairs walk the pointers around the ring.
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 6'(32 + i), 32'(100 + i), 1'b0, 1'b0, 1'b0);
      step();
      check_eq("wrap_entry", {out_valid, out_funct, out_s}, {1'b1, 6'(32 + i), 32'(100 + i)});
      check_eq("wrap_level", level, 1);
    end
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_eq("wrap_empty", empty, 1);

    // Drops, then clr together with a drop.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 6'(48 + i), 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check_eq("drop_cnt2", drop_cnt, 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("clr_with_drop", drop_cnt, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("pre_rst_level", level, 3);
    check_eq("pre_rst_head", out_funct, 6'h31);

    // Reset mid-operation beats a same-cycle push.
    rst = 1'b1;
    set_in(1'b1, 6'h2A, 32'h2A, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    set_in(1'b0, 6'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("midrst_level", level, 0);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_drop", drop_cnt, 0);
    check_eq("midrst_flags", {sticky_ov, sticky_cs}, 0);

    // Narrow counter: 4 pushes then 20 drops saturates at 15.
    in_valid4 = 1'b1;
    for (int i = 0; i < 18; i++) step();
    check_eq("sat_14", drop_cnt4, 14);
    for (int i = 0; i < 6; i++) step();
    in_valid4 = 1'b0;
    check_eq("sat_15", drop_cnt4, 15);
    check_eq("sat_full", full4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
